// File: rtl/demux_capture_pkg.sv
// Shared types and default sizing for the 1:16 bit-steering capture block.
package demux_capture_pkg;

   typedef enum logic {FILL, HOLD} cap_state_t;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned SEL_W_DEF = 4;

endpackage

// File: rtl/capture_ptr.sv
// Modulo-2^SEL_W write pointer for serial-to-parallel capture.
module capture_ptr #(
   parameter int unsigned SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [SEL_W-1:0] ptr_o
);

   logic [SEL_W-1:0] ptr_q, ptr_d;

   // Clear has priority: a drain never coincides with an accepted write anyway.
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (en_i) begin
         ptr_d = ptr_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/demux_1x16_capture.sv
// Steers a serial/selected bit stream into a registered word and hands the
// completed word out on a valid/ready handshake.
module demux_1x16_capture
   import demux_capture_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned SEL_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_bit,
   input  logic [SEL_W-1:0] sel,
   input  logic             auto_inc,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_word,
   output logic [WIDTH-1:0] fill_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             dup_err
);

   cap_state_t       state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             dup_q, dup_d;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] idx;
   logic             accept;
   logic             drain;

   assign accept = (state_q == FILL) && in_valid;
   assign drain  = (state_q == HOLD) && out_ready;
   assign idx    = auto_inc ? ptr : sel;

   capture_ptr #(
      .SEL_W (SEL_W)
   ) u_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (drain),
      .en_i  (accept && auto_inc),
      .ptr_o (ptr)
   );

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      mask_d  = mask_q;
      dup_d   = 1'b0;
      unique case (state_q)
         FILL: begin
            if (in_valid) begin
               word_d[idx] = in_bit;
               mask_d[idx] = 1'b1;
               dup_d       = mask_q[idx];
               // Completion moves to HOLD on the same edge the last bit lands.
               if (&mask_d) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = FILL;
               word_d  = '0;
               mask_d  = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         word_q  <= '0;
         mask_q  <= '0;
         dup_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         mask_q  <= mask_d;
         dup_q   <= dup_d;
      end
   end

   assign in_ready  = (state_q == FILL);
   assign out_valid = (state_q == HOLD);
   assign out_word  = word_q;
   assign fill_mask = mask_q;
   assign dup_err   = dup_q;

endmodule

// File: tb/tb_demux_1x16_capture.sv
// Randomized and directed checks of demux_1x16_capture against a behavioural model.
module tb_demux_1x16_capture;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_bit = 1'b0;
   logic [3:0]    sel = '0;
   logic          auto_inc = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  out_word;
   logic [W-1:0]  fill_mask;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          dup_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   bit m_word [W];
   bit m_mask [W];
   int m_ptr;
   bit m_hold;
   bit m_dup;

   demux_1x16_capture dut (
      .clk       (clk),
      .rst       (rst),
      .in_bit    (in_bit),
      .sel       (sel),
      .auto_inc  (auto_inc),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_word  (out_word),
      .fill_mask (fill_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dup_err   (dup_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [W-1:0] pack(input bit a [W]);
      logic [W-1:0] v = '0;
      for (int i = 0; i < W; i++) v[i] = a[i];
      return v;
   endfunction

   function automatic bit all_filled();
      for (int i = 0; i < W; i++) if (!m_mask[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < W; i++) begin
         m_word[i] = 1'b0;
         m_mask[i] = 1'b0;
      end
      m_ptr  = 0;
      m_hold = 1'b0;
      m_dup  = 1'b0;
   endtask

   // Applies the current inputs to the model as the upcoming rising edge would.
   task automatic model_edge();
      int idx;
      m_dup = 1'b0;
      if (rst) begin
         model_clear();
      end else if (!m_hold) begin
         if (in_valid) begin
            idx = auto_inc ? m_ptr : int'(sel);
            m_dup = m_mask[idx];
            m_word[idx] = in_bit;
            m_mask[idx] = 1'b1;
            if (auto_inc) m_ptr = (m_ptr + 1) % W;
            if (all_filled()) m_hold = 1'b1;
         end
      end else if (out_ready) begin
         model_clear();
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".word"},  32'(out_word),  32'(pack(m_word)));
      check({tag, ".mask"},  32'(fill_mask), 32'(pack(m_mask)));
      check({tag, ".valid"}, 32'(out_valid), 32'(m_hold));
      check({tag, ".ready"}, 32'(in_ready),  32'(!m_hold));
      check({tag, ".dup"},   32'(dup_err),   32'(m_dup));
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic drive(input bit v, input bit b, input logic [3:0] s, input bit a,
                        input bit r, input string tag);
      in_valid  = v;
      in_bit    = b;
      sel       = s;
      auto_inc  = a;
      out_ready = r;
      cycle(tag);
   endtask

   task automatic idle(input string tag);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, tag);
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      check_all("async_rst");
      rst = 1'b0;
   endtask

   initial begin
      logic [W-1:0] pat;
      int order [W];
      int n;

      model_clear();

      // 1. Reset then idle
      cycle("rst0");
      cycle("rst1");
      rst = 1'b0;
      idle("post_rst");
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.word", 32'(out_word), 32'd0);

      // 2. Explicit-select fill of 16'h674F, order 5,12,8,then the rest
      pat = 16'h674F;
      order[0] = 5; order[1] = 12; order[2] = 8;
      n = 3;
      for (int i = 0; i < W; i++) begin
         if (i != 5 && i != 12 && i != 8) begin
            order[n] = i;
            n++;
         end
      end
      for (int i = 0; i < W; i++) begin
         drive(1'b1, pat[order[i]], 4'(order[i]), 1'b0, 1'b0, "sel_fill");
         if (i == 0) begin
            check("sel5.bit", 32'(out_word[5]), 32'd0);
            check("sel5.mask", 32'(fill_mask), 32'h0020);
         end
      end
      check("sel_fill.valid", 32'(out_valid), 32'd1);
      check("sel_fill.word", 32'(out_word), 32'h674F);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "sel_drain");
      check("sel_drain.valid", 32'(out_valid), 32'd0);
      check("sel_drain.mask", 32'(fill_mask), 32'd0);

      // 3. Auto-increment serial of 16'hA017, LSB first
      pat = 16'hA017;
      for (int i = 0; i < W; i++) drive(1'b1, pat[i], 4'($urandom), 1'b1, 1'b0, "auto");
      check("auto.word", 32'(out_word), 32'hA017);
      check("auto.valid", 32'(out_valid), 32'd1);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "auto_drain");
      drive(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, "auto_wrap");
      check("auto_wrap.mask", 32'(fill_mask), 32'h0001);
      async_reset();

      // 4. Duplicate write to position 3
      drive(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, "dup_first");
      drive(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, "dup_second");
      check("dup.err", 32'(dup_err), 32'd1);
      check("dup.bit3", 32'(out_word[3]), 32'd0);
      check("dup.mask", 32'(fill_mask), 32'h0008);
      idle("dup_after");
      check("dup.pulse_end", 32'(dup_err), 32'd0);
      async_reset();

      // 5. Backpressure with in_valid held high
      pat = 16'($urandom);
      for (int i = 0; i < W; i++) drive(1'b1, pat[i], 4'd0, 1'b1, 1'b0, "bp_fill");
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, "bp_hold");
         check("bp.in_ready", 32'(in_ready), 32'd0);
         check("bp.word", 32'(out_word), 32'(pat));
      end
      drive(1'b1, 1'b1, 4'd9, 1'b0, 1'b1, "bp_drain");
      check("bp_drain.mask", 32'(fill_mask), 32'd0);
      drive(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, "bp_next");
      check("bp_next.mask", 32'(fill_mask), 32'h0200);

      // 6. Reset mid-fill, then a fresh complete word
      async_reset();
      for (int i = 0; i < 7; i++) drive(1'b1, 1'($urandom), 4'd0, 1'b1, 1'b0, "mid_fill");
      async_reset();
      check("mid_rst.mask", 32'(fill_mask), 32'd0);
      check("mid_rst.valid", 32'(out_valid), 32'd0);
      pat = 16'($urandom);
      for (int i = 0; i < W; i++) drive(1'b1, pat[i], 4'd0, 1'b1, 1'b0, "refill");
      check("refill.word", 32'(out_word), 32'(pat));
      check("refill.valid", 32'(out_valid), 32'd1);

      // 7. Randomized mixed-mode traffic
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom_range(0, 2) == 0), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
